// File: rtl/alu_arbiter.sv
// Round-robin arbiter that lets two requesters share one combinational ALU.
// One operation is in flight at a time: IDLE accepts, EXEC registers the result, RESP holds it until it is consumed.
module alu_arbiter #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid_0,
    input  logic                 req_valid_1,
    output logic                 req_ready_0,
    output logic                 req_ready_1,
    input  logic [3:0]           opcode_0,
    input  logic [3:0]           opcode_1,
    input  logic [BUS_WIDTH-1:0] a_0,
    input  logic [BUS_WIDTH-1:0] a_1,
    input  logic [BUS_WIDTH-1:0] b_0,
    input  logic [BUS_WIDTH-1:0] b_1,
    input  logic                 carry_in_0,
    input  logic                 carry_in_1,
    output logic                 rsp_valid_0,
    output logic                 rsp_valid_1,
    input  logic                 rsp_ready_0,
    input  logic                 rsp_ready_1,
    output logic [BUS_WIDTH-1:0] rsp_y,
    output logic [4:0]           rsp_flags,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [BUS_WIDTH:0] EXT_ONE = 1;

    state_t               state, state_nxt;
    logic                 prio;
    logic                 grant;
    logic [3:0]           lat_op;
    logic [BUS_WIDTH-1:0] lat_a, lat_b;
    logic                 lat_cin;
    logic                 accept;
    logic                 rsp_taken;

    logic [BUS_WIDTH-1:0] alu_y;
    logic [BUS_WIDTH:0]   ext;
    logic                 alu_carry, alu_borrow, alu_invalid;
    logic [4:0]           alu_flags;

    assign busy      = (state != IDLE);
    assign rsp_taken = grant ? rsp_ready_1 : rsp_ready_0;

    // Ready is a combinational function of valid; prio only breaks ties.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt   = state;
        req_ready_0 = 1'b0;
        req_ready_1 = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid_0 && (!req_valid_1 || !prio)) req_ready_0 = 1'b1;
                else if (req_valid_1)                       req_ready_1 = 1'b1;
                accept = req_ready_0 | req_ready_1;
                if (accept) state_nxt = EXEC;
            end
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_taken) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_y       = '0;
        ext         = '0;
        alu_carry   = 1'b0;
        alu_borrow  = 1'b0;
        alu_invalid = 1'b0;
        case (lat_op)
            4'd1: alu_y = lat_a + lat_b;
            4'd2: begin
                ext       = {1'b0, lat_a} + {1'b0, lat_b} + {{BUS_WIDTH{1'b0}}, lat_cin};
                alu_y     = ext[BUS_WIDTH-1:0];
                alu_carry = ext[BUS_WIDTH];
            end
            4'd3: begin
                ext        = {1'b0, lat_a} - {1'b0, lat_b};
                alu_y      = ext[BUS_WIDTH-1:0];
                alu_borrow = ext[BUS_WIDTH];
            end
            4'd4: begin
                ext       = {1'b0, lat_a} + EXT_ONE;
                alu_y     = ext[BUS_WIDTH-1:0];
                alu_carry = ext[BUS_WIDTH];
            end
            4'd5: begin
                ext        = {1'b0, lat_a} - EXT_ONE;
                alu_y      = ext[BUS_WIDTH-1:0];
                alu_borrow = ext[BUS_WIDTH];
            end
            4'd6:    alu_y = lat_a & lat_b;
            4'd7:    alu_y = ~lat_a;
            4'd8:    alu_y = {lat_a[BUS_WIDTH-2:0], lat_a[BUS_WIDTH-1]};
            4'd9:    alu_y = {lat_a[0], lat_a[BUS_WIDTH-1:1]};
            default: alu_invalid = 1'b1;
        endcase
    end

    assign alu_flags = {alu_invalid, ^alu_y, (alu_y == '0), alu_borrow, alu_carry};

    // Reset clears the response path too, so an interrupted operation never surfaces.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            prio        <= 1'b0;
            grant       <= 1'b0;
            lat_op      <= '0;
            lat_a       <= '0;
            lat_b       <= '0;
            lat_cin     <= 1'b0;
            rsp_valid_0 <= 1'b0;
            rsp_valid_1 <= 1'b0;
            rsp_y       <= '0;
            rsp_flags   <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            case (state)
                IDLE: if (accept) begin
                    grant   <= req_ready_1;
                    prio    <= req_ready_0;
                    lat_op  <= req_ready_1 ? opcode_1   : opcode_0;
                    lat_a   <= req_ready_1 ? a_1        : a_0;
                    lat_b   <= req_ready_1 ? b_1        : b_0;
                    lat_cin <= req_ready_1 ? carry_in_1 : carry_in_0;
                end
                EXEC: begin
                    rsp_y       <= alu_y;
                    rsp_flags   <= alu_flags;
                    rsp_valid_0 <= ~grant;
                    rsp_valid_1 <= grant;
                end
                RESP: if (rsp_taken) begin
                    rsp_valid_0 <= 1'b0;
                    rsp_valid_1 <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, arithmetic/flags, arbitration, backpressure,
// fairness and reset during an in-flight operation, with hand-computed expectations.
module tb_alu_arbiter;

    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_ADDC = 4'd2;
    localparam logic [3:0] OP_SUB  = 4'd3;
    localparam logic [3:0] OP_INC  = 4'd4;
    localparam logic [3:0] OP_DEC  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_ROL  = 4'd8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid_0, req_valid_1, req_ready_0, req_ready_1;
    logic [3:0] opcode_0, opcode_1;
    logic [7:0] a_0, a_1, b_0, b_1;
    logic       carry_in_0, carry_in_1;
    logic       rsp_valid_0, rsp_valid_1, rsp_ready_0, rsp_ready_1;
    logic [7:0] rsp_y;
    logic [4:0] rsp_flags;
    logic       busy;

    int checks = 0;
    int errors = 0;

    alu_arbiter #(.BUS_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
        .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
        .opcode_0(opcode_0), .opcode_1(opcode_1),
        .a_0(a_0), .a_1(a_1), .b_0(b_0), .b_1(b_1),
        .carry_in_0(carry_in_0), .carry_in_1(carry_in_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
        .rsp_y(rsp_y), .rsp_flags(rsp_flags), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid_0 = 0; req_valid_1 = 0; rsp_ready_0 = 0; rsp_ready_1 = 0;
        opcode_0 = '0; opcode_1 = '0; a_0 = '0; a_1 = '0; b_0 = '0; b_1 = '0;
        carry_in_0 = 0; carry_in_1 = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Drives one request and waits (bounded) for its handshake; returns one cycle later, in EXEC.
    task automatic issue(input bit port, input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic cin, output bit ok);
        ok = 0;
        if (!port) begin req_valid_0 = 1; opcode_0 = op; a_0 = a; b_0 = b; carry_in_0 = cin; end
        else       begin req_valid_1 = 1; opcode_1 = op; a_1 = a; b_1 = b; carry_in_1 = cin; end
        #1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (port ? req_ready_1 : req_ready_0) ok = 1;
            step();
        end
        if (!port) req_valid_0 = 0; else req_valid_1 = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (rsp_valid_0 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid_0: got %b expected 0", rsp_valid_0); end
        checks++; if (rsp_valid_1 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid_1: got %b expected 0", rsp_valid_1); end
        checks++; if (rsp_y !== 8'h00) begin errors++; $display("FAIL reset_rsp_y: got %h expected 00", rsp_y); end
        checks++; if (rsp_flags !== 5'b0) begin errors++; $display("FAIL reset_rsp_flags: got %b expected 00000", rsp_flags); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (req_ready_0 !== 1'b0 || req_ready_1 !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b%b expected 00", req_ready_0, req_ready_1); end
    endtask

    task automatic test_add();
        rsp_ready_0 = 1;
        req_valid_0 = 1; opcode_0 = OP_ADD; a_0 = 8'h05; b_0 = 8'h03;
        #1;
        checks++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin errors++; $display("FAIL add_ready: got %b%b expected 10", req_ready_0, req_ready_1); end
        step();
        req_valid_0 = 0;
        checks++; if (busy !== 1'b1 || rsp_valid_0 !== 1'b0) begin errors++; $display("FAIL add_exec: got busy=%b valid=%b expected busy=1 valid=0", busy, rsp_valid_0); end
        step();
        checks++; if (rsp_valid_0 !== 1'b1) begin errors++; $display("FAIL add_rsp_valid_0: got %b expected 1", rsp_valid_0); end
        checks++; if (rsp_valid_1 !== 1'b0) begin errors++; $display("FAIL add_rsp_valid_1: got %b expected 0", rsp_valid_1); end
        checks++; if (rsp_y !== 8'h08) begin errors++; $display("FAIL add_y: got %h expected 08", rsp_y); end
        checks++; if (rsp_flags !== 5'b01000) begin errors++; $display("FAIL add_flags: got %b expected 01000", rsp_flags); end
        step();
        checks++; if (rsp_valid_0 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL add_done: got valid=%b busy=%b expected 0 0", rsp_valid_0, busy); end
        checks++; if (rsp_y !== 8'h08) begin errors++; $display("FAIL add_y_hold: got %h expected 08", rsp_y); end
    endtask

    task automatic test_both_valid();
        do_reset();
        rsp_ready_0 = 1; rsp_ready_1 = 1;
        req_valid_0 = 1; opcode_0 = OP_SUB;  a_0 = 8'h03; b_0 = 8'h05;
        req_valid_1 = 1; opcode_1 = OP_ADDC; a_1 = 8'hFF; b_1 = 8'h00; carry_in_1 = 1;
        #1;
        checks++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin errors++; $display("FAIL both_first_grant: got %b%b expected 10", req_ready_0, req_ready_1); end
        step();
        req_valid_0 = 0;
        step();
        checks++; if (rsp_valid_0 !== 1'b1 || rsp_valid_1 !== 1'b0) begin errors++; $display("FAIL both_rsp0_valid: got %b%b expected 10", rsp_valid_0, rsp_valid_1); end
        checks++; if (rsp_y !== 8'hFE) begin errors++; $display("FAIL sub_y: got %h expected fe", rsp_y); end
        checks++; if (rsp_flags !== 5'b01010) begin errors++; $display("FAIL sub_flags: got %b expected 01010", rsp_flags); end
        step();
        checks++; if (req_ready_1 !== 1'b1) begin errors++; $display("FAIL both_second_grant: got %b expected 1", req_ready_1); end
        step();
        req_valid_1 = 0; carry_in_1 = 0;
        step();
        checks++; if (rsp_valid_1 !== 1'b1 || rsp_valid_0 !== 1'b0) begin errors++; $display("FAIL both_rsp1_valid: got %b%b expected 01", rsp_valid_0, rsp_valid_1); end
        checks++; if (rsp_y !== 8'h00) begin errors++; $display("FAIL addc_y: got %h expected 00", rsp_y); end
        checks++; if (rsp_flags !== 5'b00101) begin errors++; $display("FAIL addc_flags: got %b expected 00101", rsp_flags); end
        step();
    endtask

    task automatic test_invalid_and_rol();
        bit ok;
        rsp_ready_0 = 1;
        issue(0, 4'h0, 8'h12, 8'h00, 0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL invalid_handshake: got timeout expected accept"); end
        step();
        checks++; if (rsp_y !== 8'h00 || rsp_flags !== 5'b10100) begin errors++; $display("FAIL invalid_result: got y=%h f=%b expected y=00 f=10100", rsp_y, rsp_flags); end
        step();
        issue(0, OP_ROL, 8'h81, 8'h00, 0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rol_handshake: got timeout expected accept"); end
        step();
        checks++; if (rsp_y !== 8'h03 || rsp_flags !== 5'b00000) begin errors++; $display("FAIL rol_result: got y=%h f=%b expected y=03 f=00000", rsp_y, rsp_flags); end
        step();
    endtask

    task automatic test_backpressure();
        bit ok;
        rsp_ready_1 = 0;
        issue(1, OP_NOT, 8'h0F, 8'h00, 0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_handshake: got timeout expected accept"); end
        req_valid_0 = 1; opcode_0 = OP_ADD; a_0 = 8'h01; b_0 = 8'h01; rsp_ready_0 = 1;
        #1;
        checks++; if (req_ready_0 !== 1'b0) begin errors++; $display("FAIL bp_ready_exec: got %b expected 0", req_ready_0); end
        step();
        for (int i = 0; i < 5; i++) begin
            checks++; if (rsp_valid_1 !== 1'b1 || rsp_y !== 8'hF0 || rsp_flags !== 5'b00000)
                begin errors++; $display("FAIL bp_hold[%0d]: got v=%b y=%h f=%b expected v=1 y=f0 f=00000", i, rsp_valid_1, rsp_y, rsp_flags); end
            checks++; if (req_ready_0 !== 1'b0 || rsp_valid_0 !== 1'b0)
                begin errors++; $display("FAIL bp_block[%0d]: got ready0=%b valid0=%b expected 0 0", i, req_ready_0, rsp_valid_0); end
            step();
        end
        rsp_ready_1 = 1;
        step();
        checks++; if (rsp_valid_1 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release: got v=%b busy=%b expected 0 0", rsp_valid_1, busy); end
        checks++; if (req_ready_0 !== 1'b1) begin errors++; $display("FAIL bp_next_accept: got %b expected 1", req_ready_0); end
        step();
        req_valid_0 = 0;
        step();
        checks++; if (rsp_valid_0 !== 1'b1 || rsp_y !== 8'h02 || rsp_flags !== 5'b01000)
            begin errors++; $display("FAIL bp_followup: got v=%b y=%h f=%b expected v=1 y=02 f=01000", rsp_valid_0, rsp_y, rsp_flags); end
        step();
    endtask

    task automatic test_fairness();
        logic [7:0] exp_y;
        do_reset();
        rsp_ready_0 = 1; rsp_ready_1 = 1;
        req_valid_0 = 1; opcode_0 = OP_ADD; a_0 = 8'h01; b_0 = 8'h01;
        req_valid_1 = 1; opcode_1 = OP_ADD; a_1 = 8'h10; b_1 = 8'h20;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_y = (i % 2 == 0) ? 8'h02 : 8'h30;
            checks++; if ({req_ready_0, req_ready_1} !== ((i % 2 == 0) ? 2'b10 : 2'b01))
                begin errors++; $display("FAIL fair_grant[%0d]: got %b%b expected port %0d", i, req_ready_0, req_ready_1, i % 2); end
            step();
            step();
            checks++; if ({rsp_valid_0, rsp_valid_1} !== ((i % 2 == 0) ? 2'b10 : 2'b01) || rsp_y !== exp_y)
                begin errors++; $display("FAIL fair_rsp[%0d]: got v=%b%b y=%h expected port %0d y=%h", i, rsp_valid_0, rsp_valid_1, rsp_y, i % 2, exp_y); end
            step();
        end
        req_valid_0 = 0; req_valid_1 = 0;
        step();
    endtask

    task automatic test_reset_exec();
        bit ok;
        rsp_ready_0 = 1; rsp_ready_1 = 1;
        issue(0, OP_INC, 8'h07, 8'h00, 0, ok);
        checks++; if (!ok || busy !== 1'b1) begin errors++; $display("FAIL rexec_setup: got ok=%b busy=%b expected 1 1", ok, busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (rsp_valid_0 !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rexec_async: got v=%b busy=%b expected 0 0", rsp_valid_0, busy); end
        checks++; if (rsp_y !== 8'h00 || rsp_flags !== 5'b0) begin errors++; $display("FAIL rexec_clear: got y=%h f=%b expected 00 00000", rsp_y, rsp_flags); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rsp_valid_0 !== 1'b0 || rsp_valid_1 !== 1'b0)
                begin errors++; $display("FAIL rexec_stale[%0d]: got %b%b expected 00", i, rsp_valid_0, rsp_valid_1); end
            step();
        end
        req_valid_0 = 1; opcode_0 = OP_INC; a_0 = 8'h07;
        req_valid_1 = 1; opcode_1 = OP_DEC; a_1 = 8'h00;
        #1;
        checks++; if (req_ready_0 !== 1'b1 || req_ready_1 !== 1'b0) begin errors++; $display("FAIL rexec_prio: got %b%b expected 10", req_ready_0, req_ready_1); end
        step();
        req_valid_0 = 0;
        step();
        checks++; if (rsp_valid_0 !== 1'b1 || rsp_y !== 8'h08 || rsp_flags !== 5'b01000)
            begin errors++; $display("FAIL inc_result: got v=%b y=%h f=%b expected v=1 y=08 f=01000", rsp_valid_0, rsp_y, rsp_flags); end
        step();
        step();
        req_valid_1 = 0;
        step();
        checks++; if (rsp_valid_1 !== 1'b1 || rsp_y !== 8'hFF || rsp_flags !== 5'b00010)
            begin errors++; $display("FAIL dec_result: got v=%b y=%h f=%b expected v=1 y=ff f=00010", rsp_valid_1, rsp_y, rsp_flags); end
        step();
    endtask

    initial begin
        test_reset();
        test_add();
        test_both_valid();
        test_invalid_and_rol();
        test_backpressure();
        test_fairness();
        test_reset_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
